// File: rtl/pcis_abd_wr_demux.sv
// PCIS (BAR4) AXI4 write terminator: decodes each burst into one of NUM_APPS
// address windows, forwards beats as addressed ABD writes, and answers B after the last consume.
module pcis_abd_wr_demux #(
  parameter int NUM_APPS      = 4,
  parameter int DATA_W        = 512,
  parameter int ID_W          = 6,
  parameter int APP_ADDR_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_W-1:0]       sh_cl_dma_pcis_awid,
  input  logic [63:0]           sh_cl_dma_pcis_awaddr,
  input  logic [7:0]            sh_cl_dma_pcis_awlen,
  input  logic [2:0]            sh_cl_dma_pcis_awsize,
  input  logic                  sh_cl_dma_pcis_awvalid,
  output logic                  cl_sh_dma_pcis_awready,
  input  logic [DATA_W-1:0]     sh_cl_dma_pcis_wdata,
  input  logic [DATA_W/8-1:0]   sh_cl_dma_pcis_wstrb,
  input  logic                  sh_cl_dma_pcis_wlast,
  input  logic                  sh_cl_dma_pcis_wvalid,
  output logic                  cl_sh_dma_pcis_wready,
  output logic [ID_W-1:0]       cl_sh_dma_pcis_bid,
  output logic [1:0]            cl_sh_dma_pcis_bresp,
  output logic                  cl_sh_dma_pcis_bvalid,
  input  logic                  sh_cl_dma_pcis_bready,
  input  logic [NUM_APPS-1:0]   app_en,
  output logic [NUM_APPS-1:0]   app_wr_valid,
  input  logic [NUM_APPS-1:0]   app_wr_ready,
  output logic [63:0]           app_wr_addr,
  output logic [DATA_W-1:0]     app_wr_data,
  output logic [DATA_W/8-1:0]   app_wr_strb,
  output logic                  app_wr_last,
  output logic [31:0]           drop_count
);
  localparam int BYTES      = DATA_W / 8;
  localparam int BYTE_SHIFT = $clog2(BYTES);
  localparam int APP_SEL_W  = (NUM_APPS > 1) ? $clog2(NUM_APPS) : 1;
  localparam logic [63:0] WIN_MASK = (APP_ADDR_BITS >= 64) ? '1 : ((64'd1 << APP_ADDR_BITS) - 64'd1);

  // state   | meaning
  // S_IDLE  | awready high, waiting for a burst
  // S_DATA  | forwarding beats to the selected app
  // S_DROP  | accepting and discarding beats up to wlast
  // S_DRAIN | waiting for the last forwarded beat to be consumed
  // S_RESP  | presenting the B response
  typedef enum logic [2:0] {S_IDLE, S_DATA, S_DROP, S_DRAIN, S_RESP} state_t;

  state_t                 state_q;
  logic                   awready_q;
  logic                   bvalid_q;
  logic [ID_W-1:0]        id_q;
  logic [7:0]             len_q;
  logic [63:0]            base_q;
  logic [APP_SEL_W-1:0]   app_q;
  logic [8:0]             cnt_q;
  logic [1:0]             resp_q;
  logic [NUM_APPS-1:0]    valid_q;
  logic [63:0]            addr_q;
  logic [DATA_W-1:0]      data_q;
  logic [BYTES-1:0]       strb_q;
  logic                   last_q;
  logic [31:0]            drop_cnt_q;

  logic [APP_SEL_W-1:0]   aw_app;
  logic                   aw_oor;
  logic                   aw_bad;
  logic                   consume;
  logic                   out_free;
  logic                   wready;
  logic                   aw_hs;
  logic                   w_hs;
  logic                   cnt_at_len;
  logic [63:0]            beat_addr;

  always_comb begin
    aw_app = (NUM_APPS > 1) ? sh_cl_dma_pcis_awaddr[APP_ADDR_BITS +: APP_SEL_W] : '0;
    aw_oor = (sh_cl_dma_pcis_awaddr >> APP_ADDR_BITS) >= 64'(NUM_APPS);
    aw_bad = !app_en[aw_app]
          || (sh_cl_dma_pcis_awsize != 3'(BYTE_SHIFT))
          || (sh_cl_dma_pcis_awaddr[BYTE_SHIFT-1:0] != '0);
  end

  assign consume    = |(valid_q & app_wr_ready);
  assign out_free   = (valid_q == '0) || consume;
  assign wready     = ((state_q == S_DATA) && out_free) || (state_q == S_DROP);
  assign aw_hs      = sh_cl_dma_pcis_awvalid && awready_q;
  assign w_hs       = sh_cl_dma_pcis_wvalid && wready;
  assign cnt_at_len = (cnt_q == {1'b0, len_q});
  assign beat_addr  = base_q + (64'(cnt_q) << BYTE_SHIFT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      id_q       <= '0;
      len_q      <= '0;
      base_q     <= '0;
      app_q      <= '0;
      cnt_q      <= '0;
      resp_q     <= 2'b00;
      valid_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      last_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (consume) valid_q <= '0;
      case (state_q)
        S_IDLE: begin
          awready_q <= 1'b1;
          if (aw_hs) begin
            awready_q <= 1'b0;
            id_q      <= sh_cl_dma_pcis_awid;
            len_q     <= sh_cl_dma_pcis_awlen;
            base_q    <= sh_cl_dma_pcis_awaddr & WIN_MASK;
            app_q     <= aw_app;
            cnt_q     <= '0;
            if (aw_oor) begin
              resp_q  <= 2'b11;
              state_q <= S_DROP;
            end else if (aw_bad) begin
              resp_q  <= 2'b10;
              state_q <= S_DROP;
            end else begin
              resp_q  <= 2'b00;
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_hs) begin
            valid_q <= NUM_APPS'(1) << app_q;
            addr_q  <= beat_addr;
            data_q  <= sh_cl_dma_pcis_wdata;
            strb_q  <= sh_cl_dma_pcis_wstrb;
            last_q  <= cnt_at_len || sh_cl_dma_pcis_wlast;
            cnt_q   <= cnt_q + 9'd1;
            if (sh_cl_dma_pcis_wlast) begin
              if (!cnt_at_len) resp_q <= 2'b10;
              state_q <= S_DRAIN;
            end else if (cnt_at_len) begin
              resp_q  <= 2'b10;
              state_q <= S_DROP;
            end
          end
        end
        S_DROP: begin
          // a truncated burst may still have its last beat waiting in the output register
          if (w_hs && sh_cl_dma_pcis_wlast) begin
            if (out_free) begin
              state_q  <= S_RESP;
              bvalid_q <= 1'b1;
            end else begin
              state_q  <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (out_free) begin
            state_q  <= S_RESP;
            bvalid_q <= 1'b1;
          end
        end
        S_RESP: begin
          if (sh_cl_dma_pcis_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            state_q   <= S_IDLE;
            if ((resp_q != 2'b00) && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 32'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cl_sh_dma_pcis_awready = awready_q;
  assign cl_sh_dma_pcis_wready  = wready;
  assign cl_sh_dma_pcis_bid     = id_q;
  assign cl_sh_dma_pcis_bresp   = resp_q;
  assign cl_sh_dma_pcis_bvalid  = bvalid_q;
  assign app_wr_valid           = valid_q;
  assign app_wr_addr            = addr_q;
  assign app_wr_data            = data_q;
  assign app_wr_strb            = strb_q;
  assign app_wr_last            = last_q;
  assign drop_count             = drop_cnt_q;
endmodule

// File: tb/tb_pcis_abd_wr_demux.sv
// Bench for pcis_abd_wr_demux: directed and randomized bursts checked against a
// queue-based model of the forwarded beats and B response.
module tb_pcis_abd_wr_demux;
  localparam int NUM_APPS = 4;
  localparam int DATA_W   = 512;
  localparam int ID_W     = 6;
  localparam int AAB      = 32;
  localparam int BYTES    = DATA_W / 8;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [ID_W-1:0]     awid = '0;
  logic [63:0]         awaddr = '0;
  logic [7:0]          awlen = '0;
  logic [2:0]          awsize = '0;
  logic                awvalid = 1'b0;
  logic                awready;
  logic [DATA_W-1:0]   wdata = '0;
  logic [BYTES-1:0]    wstrb = '0;
  logic                wlast = 1'b0;
  logic                wvalid = 1'b0;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready = 1'b0;
  logic [NUM_APPS-1:0] app_en = '1;
  logic [NUM_APPS-1:0] app_wr_valid;
  logic [NUM_APPS-1:0] app_wr_ready = '1;
  logic [63:0]         app_wr_addr;
  logic [DATA_W-1:0]   app_wr_data;
  logic [BYTES-1:0]    app_wr_strb;
  logic                app_wr_last;
  logic [31:0]         drop_count;

  always #5 clk = ~clk;

  pcis_abd_wr_demux #(.NUM_APPS(NUM_APPS), .DATA_W(DATA_W), .ID_W(ID_W), .APP_ADDR_BITS(AAB)) dut (
    .clk(clk), .rst(rst),
    .sh_cl_dma_pcis_awid(awid), .sh_cl_dma_pcis_awaddr(awaddr), .sh_cl_dma_pcis_awlen(awlen),
    .sh_cl_dma_pcis_awsize(awsize), .sh_cl_dma_pcis_awvalid(awvalid), .cl_sh_dma_pcis_awready(awready),
    .sh_cl_dma_pcis_wdata(wdata), .sh_cl_dma_pcis_wstrb(wstrb), .sh_cl_dma_pcis_wlast(wlast),
    .sh_cl_dma_pcis_wvalid(wvalid), .cl_sh_dma_pcis_wready(wready),
    .cl_sh_dma_pcis_bid(bid), .cl_sh_dma_pcis_bresp(bresp), .cl_sh_dma_pcis_bvalid(bvalid),
    .sh_cl_dma_pcis_bready(bready),
    .app_en(app_en), .app_wr_valid(app_wr_valid), .app_wr_ready(app_wr_ready),
    .app_wr_addr(app_wr_addr), .app_wr_data(app_wr_data), .app_wr_strb(app_wr_strb),
    .app_wr_last(app_wr_last), .drop_count(drop_count)
  );

  typedef struct {
    int                app;
    logic [63:0]       addr;
    logic [DATA_W-1:0] data;
    logic [BYTES-1:0]  strb;
    logic              last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  logic [31:0] drop_model = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_wide(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_awready"}, awready, 0);
    check({tag, "_wready"}, wready, 0);
    check({tag, "_bvalid"}, bvalid, 0);
    check({tag, "_bresp"}, bresp, 0);
    check({tag, "_bid"}, bid, 0);
    check({tag, "_valid"}, app_wr_valid, 0);
    check({tag, "_addr"}, app_wr_addr, 0);
    check_wide({tag, "_data"}, app_wr_data, '0);
    check({tag, "_strb"}, app_wr_strb, 0);
    check({tag, "_last"}, app_wr_last, 0);
    check({tag, "_drop_count"}, drop_count, 0);
  endtask

  // One burst: model the expected beats/response from the address rules, then drive and check.
  task automatic run_burst(input string name, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input int nbeats, input logic [3:0] en,
                           input bit rnd, input int abort_iter);
    logic [DATA_W-1:0] wd[$];
    logic [BYTES-1:0]  ws[$];
    logic [DATA_W-1:0] tmp;
    logic [ID_W-1:0]   id;
    logic [1:0]        exp_resp;
    beat_t             e;
    int app, fwd, sent, iter, waited, last_cons, nseen;
    bit done;

    id = ID_W'($urandom);
    for (int i = 0; i < nbeats; i++) begin
      for (int k = 0; k < DATA_W / 32; k++) tmp[32*k +: 32] = $urandom;
      wd.push_back(tmp);
      ws.push_back({$urandom, $urandom});
    end

    app = int'(addr[33:32]);
    if (addr >= 64'h4_0000_0000) exp_resp = 2'b11;
    else if (!en[app] || size != 3'd6 || addr[5:0] != 6'd0) exp_resp = 2'b10;
    else exp_resp = 2'b00;
    if (exp_resp != 2'b00) fwd = 0;
    else fwd = (nbeats < int'(len) + 1) ? nbeats : int'(len) + 1;
    if (exp_resp == 2'b00 && nbeats != int'(len) + 1) exp_resp = 2'b10;
    for (int i = 0; i < fwd; i++) begin
      e.app  = app;
      e.addr = (addr & 64'hFFFF_FFFF) + 64'(i) * 64;
      e.data = wd[i];
      e.strb = ws[i];
      e.last = (i == fwd - 1);
      exp_q.push_back(e);
    end

    @(negedge clk);
    app_en = en; awid = id; awaddr = addr; awlen = len; awsize = size; awvalid = 1'b1;
    waited = 0;
    #1;
    while (!awready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check({name, "_aw_accept"}, awready, 1);
    if (!awready) begin
      awvalid = 1'b0;
      exp_q.delete();
      return;
    end
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    if (rnd) app_en = 4'($urandom);

    sent = 0; iter = 0; waited = 0; last_cons = -10; nseen = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      iter++;
      if (abort_iter > 0 && iter >= abort_iter) return;
      app_wr_ready = rnd ? 4'($urandom) : 4'hF;
      if (sent < nbeats && (!rnd || $urandom_range(0, 3) != 0)) begin
        wvalid = 1'b1; wdata = wd[sent]; wstrb = ws[sent]; wlast = (sent == nbeats - 1);
      end else begin
        wvalid = 1'b0; wlast = 1'b0;
      end
      #1;
      if (bvalid) begin
        check({name, "_b_all_forwarded"}, exp_q.size(), 0);
        check({name, "_b_all_w_taken"}, sent, nbeats);
        if (fwd > 0 && nbeats <= int'(len) + 1) check({name, "_b_latency"}, cyc, last_cons + 1);
        check({name, "_bid"}, bid, id);
        check({name, "_bresp"}, bresp, exp_resp);
        check({name, "_valid_idle_at_b"}, app_wr_valid, 0);
        bready = 1'b1;
        @(posedge clk);
        #1;
        bready = 1'b0;
        if (exp_resp != 2'b00 && drop_model != 32'hFFFF_FFFF) drop_model++;
        check({name, "_awready_after_b"}, awready, 1);
        check({name, "_drop_count"}, drop_count, drop_model);
        done = 1;
      end else begin
        if (app_wr_valid != '0) begin
          check({name, "_beat_expected"}, exp_q.size() != 0, 1);
          if ((app_wr_valid & app_wr_ready) != '0 && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({name, "_valid"}, app_wr_valid, 64'(1) << e.app);
            check({name, "_addr"}, app_wr_addr, e.addr);
            check_wide({name, "_data"}, app_wr_data, e.data);
            check({name, "_strb"}, app_wr_strb, e.strb);
            check({name, "_last"}, app_wr_last, e.last);
            if (!rnd && nseen > 0) check({name, "_throughput"}, cyc, last_cons + 1);
            last_cons = cyc;
            nseen++;
          end
        end
        if (wvalid && wready) sent++;
        waited++;
        if (waited > 5000) begin
          check({name, "_b_timeout"}, bvalid, 1);
          done = 1;
        end
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    logic [63:0] a;
    logic [7:0]  l;
    int          nb;
    int          ap;

    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("awready_after_release", awready, 1);

    run_burst("basic", 64'h2_0000_0040, 8'd3, 3'd6, 4, 4'hF, 0, 0);
    run_burst("out_of_range", 64'h4_0000_0000, 8'd1, 3'd6, 2, 4'hF, 0, 0);
    run_burst("disabled_app", 64'h1_0000_0000, 8'd1, 3'd6, 2, 4'b1101, 0, 0);
    run_burst("early_wlast", 64'h3_0000_1000, 8'd7, 3'd6, 3, 4'hF, 0, 0);
    run_burst("late_wlast", 64'h0_0000_0080, 8'd1, 3'd6, 4, 4'hF, 0, 0);
    run_burst("bad_size", 64'h2_0000_0000, 8'd0, 3'd5, 1, 4'hF, 0, 0);
    run_burst("misaligned", 64'h1_0000_0020, 8'd2, 3'd6, 3, 4'hF, 0, 0);
    run_burst("long_gaps", 64'h3_0000_1000, 8'd255, 3'd6, 256, 4'hF, 1, 0);

    for (int k = 0; k < 8; k++) begin
      ap = $urandom_range(0, 3);
      l  = 8'($urandom_range(0, 15));
      a  = {30'd0, 2'(ap), $urandom & 32'hFFFF_FFC0};
      case ($urandom_range(0, 4))
        0:       nb = int'(l) + 2;
        1:       nb = (l == 0) ? 1 : int'(l);
        default: nb = int'(l) + 1;
      endcase
      run_burst("random", a, l, 3'd6, nb, 4'($urandom) | 4'(1 << ap), 1, 0);
    end
    run_burst("random_late_wlast_gaps", 64'h1_0000_0400, 8'd2, 3'd6, 6, 4'hF, 1, 0);

    run_burst("aborted", 64'h1_0000_0000, 8'd7, 3'd6, 8, 4'hF, 0, 4);
    #2;
    rst = 1'b0;
    #1;
    wvalid = 1'b0; wlast = 1'b0; awvalid = 1'b0; bready = 1'b0;
    drop_model = '0;
    exp_q.delete();
    check_reset_values("midburst_reset");
    repeat (2) @(posedge clk);
    #1;
    check("awready_held_in_reset", awready, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("awready_after_rerelease", awready, 1);
    check("no_b_after_reset", bvalid, 0);
    run_burst("after_reset", 64'h2_0000_0100, 8'd3, 3'd6, 4, 4'hF, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
